uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  UART transmit serializer. Sits directly downstream of the baud tick generator:
//  drives its enable and consumes its one-clock tick pulses (Oversampling = 1).
//  Accepts parallel bytes from the FIR output path over a valid/ready handshake.
//  Shifts each byte onto the tx line as a start bit, data bits LSB first,
//  optional parity, then stop bits.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, legal range 5..9
//  STOP_BITS   1   stop bits per frame, 1 or 2
//  PARITY_ODD  0   0 = even parity, 1 = odd parity; used only under UART_TX_PARITY_EN
// PORTS
//  clk         in   1          system clock; all logic on posedge
//  rst         in   1          reset, synchronous, active-low
//  data_in     in   DATA_BITS  byte to send; sampled on the accept edge
//  data_valid  in   1          upstream has a byte
//  data_ready  out  1          serializer can accept a byte
//  tick        in   1          one-clk baud pulse from the baud tick generator
//  baud_en     out  1          enable to the baud tick generator
//  tx          out  1          serial line, idle high
//  busy        out  1          frame in progress
// BEHAVIOUR
//  Reset (rst = 0 at a posedge): state = IDLE, tx = 1, baud_en = 0, busy = 0,
//   data_ready = 0, bit counter = 0, shift register = 0.
//   data_ready may rise no earlier than the first edge with rst = 1.
//  data_ready = 1 only in IDLE. Accept = data_valid & data_ready at a posedge.
//  States and transitions:
//   IDLE   -> START on accept. Latch data_in into the shift register.
//             Same edge: tx <= 0, baud_en <= 1, busy <= 1, data_ready <= 0.
//   START  -> DATA on tick. tx <= shift[0]; bit counter <= 0.
//   DATA   on tick: shift right; tx <= next bit; counter++.
//             After DATA_BITS bits: go to PARITY if enabled, else STOP (tx <= 1).
//   PARITY -> STOP on tick; tx <= 1.
//   STOP   on tick: counter++. After STOP_BITS ticks: IDLE, baud_en <= 0,
//             busy <= 0, data_ready <= 1.
//  Every bit is held for exactly one tick interval.
//  Frame length = 1 + DATA_BITS + P + STOP_BITS ticks (P = 1 with parity, else 0).
//  tick in IDLE is ignored. data_valid outside IDLE is ignored; data_in is
//   don't-care after accept.
//  Back-to-back: a byte accepted on the edge after STOP exits produces a start bit
//   1 clk later. The line shows no extra idle beyond the stop bits plus 1 clk.
//  baud_en falls with the final stop tick, so the generator count restarts at 0
//   for the next frame (its tick clears the count).
//  Reset mid-frame: the frame is abandoned. tx = 1 and baud_en = 0 on the next
//   edge; no partial byte is resent.
//  tick coincident with rst = 0: reset wins.
//  tx, baud_en, busy and data_ready are all registered; no combinational path
//   from inputs to outputs.
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//   PARITY state is present; the parity bit is sent after the last data bit.
//   Even parity: parity bit = ^data. Odd parity: parity bit = ~^data.
//   The parity value is computed at accept from the latched byte.
//  UART_TX_PARITY_EN undefined:
//   No PARITY state and no parity logic; PARITY_ODD is ignored.
//   DATA goes straight to STOP.
// TESTING
//  (bench drives tick every 4 clks while baud_en = 1; DATA_BITS = 8, STOP_BITS = 1)
//  1. rst = 0 for 3 clks, then release -> tx = 1, baud_en = 0, busy = 0 during
//     reset; data_ready = 1 from the 1st edge after release.
//  2. Send 0xA5 -> tx sequence per tick: 0,1,0,1,0,0,1,0,1,1
//     (10 bits, or 11 with parity).
//     busy = 1 for the whole frame; data_ready = 0 until the stop tick.
//  3. Hold data_valid with 0x00 then 0xFF back-to-back -> second start bit
//     exactly 1 clk after the first frame's stop tick.
//     Exactly 2 accepts are observed.
//  4. Pulse tick for 5 clks in IDLE with data_valid = 0 -> tx stays 1,
//     state unchanged, baud_en = 0.
//  5. Assert rst = 0 during data bit 3 -> next edge: tx = 1, baud_en = 0,
//     busy = 0. After release, a new byte 0x3C is sent correctly.
//  6. UART_TX_PARITY_EN, PARITY_ODD = 0:
//     0x07 -> parity bit 1; 0x03 -> parity bit 0.
//     With PARITY_ODD = 1 the parity bits are inverted.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit serializer.
// Accepts a parallel word over a valid/ready handshake and shifts it onto the
// tx line as start bit, DATA_BITS data bits (LSB first), optional parity bit
// and STOP_BITS stop bits. Bit timing comes from one-clock tick pulses of an
// external baud tick generator, whose enable (baud_en) this block drives.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the
// last data bit (PARITY_ODD selects odd parity). With the macro undefined
// there is no parity state or logic and PARITY_ODD is ignored.
// All outputs are registered; reset is synchronous and active-low.
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic                 tick,
  output logic                 baud_en,
  output logic                 tx,
  output logic                 busy
);

  // Counter covers both the data-bit index (up to 9) and the stop-bit index.
  localparam int               CNT_W     = 4;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  // Reject configurations the serializer is not built for.
  if ((DATA_BITS < 5) || (DATA_BITS > 9) || (STOP_BITS < 1) || (STOP_BITS > 2) ||
      (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_cfg
    $error("uart_tx_serializer: illegal DATA_BITS/STOP_BITS/PARITY_ODD");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t               state_q;
  logic                 tx_q;
  logic                 baud_en_q;
  logic                 busy_q;
  logic                 ready_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;

  // Next values of the bit counter and the shift register on a data tick.
  assign cnt_d   = cnt_q + CNT_W'(1);
  assign shift_d = {1'b0, shift_q[DATA_BITS-1:1]};

`ifdef UART_TX_PARITY_EN
  logic parity_q;
  logic parity_d;

  // Parity is taken from the word at accept so data_in is don't-care later.
  assign parity_d = (PARITY_ODD != 0) ? ~^data_in : ^data_in;
`endif

  // Frame sequencer: one state per line segment, outputs updated with the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      tx_q      <= 1'b1;
      baud_en_q <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      cnt_q     <= '0;
      shift_q   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          // ready_q is low on the first edge after reset, so no accept can
          // happen before it has been visible for a full cycle.
          if (data_valid && ready_q) begin
            shift_q   <= data_in;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
            tx_q      <= 1'b0;
            baud_en_q <= 1'b1;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            state_q   <= ST_START;
          end else begin
            ready_q   <= 1'b1;
          end
        end

        ST_START: begin
          if (tick) begin
            tx_q    <= shift_q[0];
            cnt_q   <= '0;
            state_q <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (tick) begin
            shift_q <= shift_d;
            if (cnt_q == LAST_DATA) begin
              cnt_q   <= '0;
`ifdef UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= ST_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
`endif
            end else begin
              tx_q    <= shift_q[1];
              cnt_q   <= cnt_d;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            tx_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (tick) begin
            if (cnt_q == LAST_STOP) begin
              // Dropping baud_en here lets the generator restart its count
              // from zero for a back-to-back frame.
              cnt_q     <= '0;
              baud_en_q <= 1'b0;
              busy_q    <= 1'b0;
              ready_q   <= 1'b1;
              state_q   <= ST_IDLE;
            end else begin
              cnt_q     <= cnt_d;
            end
          end
        end

        default: begin
          tx_q      <= 1'b1;
          baud_en_q <= 1'b0;
          busy_q    <= 1'b0;
          ready_q   <= 1'b0;
          cnt_q     <= '0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign baud_en    = baud_en_q;
  assign busy       = busy_q;
  assign data_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer: baud generator stand-in (tick every 4 clks
// while baud_en), queue-based frame model, directed and randomized traffic.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS   = 1;
`else
  localparam int PAR_BITS   = 0;
`endif
  localparam int FRAME_LEN  = 1 + DATA_BITS + PAR_BITS + STOP_BITS;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [DATA_BITS-1:0] data_in = '0;
  logic                 data_valid = 1'b0;
  logic                 data_ready;
  logic                 tick;
  logic                 tick_gen = 1'b0;
  logic                 tick_extra = 1'b0;
  logic                 baud_en;
  logic                 tx;
  logic                 busy;

  assign tick = tick_gen | tick_extra;

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .DATA_BITS (DATA_BITS),
    .STOP_BITS (STOP_BITS),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .tick      (tick),
    .baud_en   (baud_en),
    .tx        (tx),
    .busy      (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Baud generator stand-in: count clocks while enabled, tick on every 4th.
  int gcnt = 0;
  always @(negedge clk) begin
    if (baud_en !== 1'b1) begin
      gcnt     = 0;
      tick_gen = 1'b0;
    end else begin
      gcnt++;
      if (gcnt == 4) begin
        tick_gen = 1'b1;
        gcnt     = 0;
      end else begin
        tick_gen = 1'b0;
      end
    end
  end

  // Reference model: queue of line bits still owed by accepted frames.
  bit          exp_q[$];
  int          acc_cnt    = 0;
  int          pop_cnt    = 0;
  int          cyc        = 0;
  int          stop_cyc   = -100;
  int          last_gap   = 0;
  bit          start_pend = 1'b0;
  logic [15:0] cap        = '0;
  int          cap_n      = 0;

  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (rst !== 1'b1) begin
      exp_q.delete();
      start_pend = 1'b0;
    end else begin
      chk("busy", 32'(busy), 32'(exp_q.size() > 0));
      chk("baud_en", 32'(baud_en), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) chk("ready_in_frame", 32'(data_ready), 32'(0));
      if (start_pend) begin
        chk("start_bit", 32'(tx), 32'(0));
        start_pend = 1'b0;
      end
      if (tick) begin
        cap = {cap[14:0], tx};
        cap_n++;
        if (exp_q.size() > 0) begin
          chk("tx_bit", 32'(tx), 32'(exp_q.pop_front()));
          pop_cnt++;
          if (exp_q.size() == 0) stop_cyc = cyc;
        end else begin
          chk("tx_idle_tick", 32'(tx), 32'(1));
        end
      end
      if (data_valid && data_ready) begin
        exp_q.push_back(1'b0);
        for (int i = 0; i < DATA_BITS; i++) exp_q.push_back(data_in[i]);
`ifdef UART_TX_PARITY_EN
        exp_q.push_back((^data_in) ^ (PARITY_ODD != 0));
`endif
        for (int i = 0; i < STOP_BITS; i++) exp_q.push_back(1'b1);
        acc_cnt++;
        last_gap   = cyc - stop_cyc;
        start_pend = 1'b1;
      end
    end
  end

  // Called on a negedge; returns on the first negedge after the accept edge.
  task automatic wait_acc(input int target);
    int b = 0;
    #2;
    while (acc_cnt < target && b < 200) begin
      @(negedge clk);
      #2;
      b++;
    end
    chk("accept_seen", 32'(acc_cnt >= target), 32'(1));
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int b = 0;
    #2;
    while ((exp_q.size() != 0 || busy !== 1'b0) && b < 400) begin
      @(negedge clk);
      #2;
      b++;
    end
    chk("idle_reached", 32'(exp_q.size() == 0 && busy === 1'b0), 32'(1));
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [DATA_BITS-1:0] d);
    int a = acc_cnt;
    data_in    = d;
    data_valid = 1'b1;
    wait_acc(a + 1);
    data_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int p;
    int b;

    // Reset held for 3 clocks, then release.
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #2;
      chk("rst_tx", 32'(tx), 32'(1));
      chk("rst_baud_en", 32'(baud_en), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_ready", 32'(data_ready), 32'(0));
    end
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("ready_before_edge", 32'(data_ready), 32'(0));
    @(negedge clk);
    #2;
    chk("ready_after_release", 32'(data_ready), 32'(1));
    chk("idle_tx", 32'(tx), 32'(1));

    // Single frame 0xA5.
    @(negedge clk);
    cap_n = 0;
    send_byte(8'hA5);
    wait_idle();
    chk("a5_len", 32'(cap_n), 32'(FRAME_LEN));
`ifdef UART_TX_PARITY_EN
    chk("a5_bits", 32'(cap[10:0]), 32'(11'b01010010101));
`else
    chk("a5_bits", 32'(cap[9:0]), 32'(10'b0101001011));
`endif
    chk("ready_after_frame", 32'(data_ready), 32'(1));

    // Back-to-back 0x00 then 0xFF with data_valid held high.
    a          = acc_cnt;
    data_in    = 8'h00;
    data_valid = 1'b1;
    wait_acc(a + 1);
    data_in    = 8'hFF;
    wait_acc(a + 2);
    data_valid = 1'b0;
    chk("b2b_gap", 32'(last_gap), 32'(1));
    wait_idle();
    repeat (10) @(negedge clk);
    chk("b2b_accepts", 32'(acc_cnt - a), 32'(2));

    // Ticks while idle are ignored.
    tick_extra = 1'b1;
    repeat (5) @(negedge clk);
    tick_extra = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #2;
      chk("idle_tick_tx", 32'(tx), 32'(1));
      chk("idle_tick_baud_en", 32'(baud_en), 32'(0));
      chk("idle_tick_busy", 32'(busy), 32'(0));
      chk("idle_tick_ready", 32'(data_ready), 32'(1));
    end

    // Reset during data bit 3, then a clean 0x3C frame.
    @(negedge clk);
    send_byte(8'h5A);
    p = pop_cnt;
    b = 0;
    #2;
    while (pop_cnt < p + 4 && b < 100) begin
      @(negedge clk);
      #2;
      b++;
    end
    chk("reach_bit3", 32'(pop_cnt >= p + 4), 32'(1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2;
    chk("midrst_tx", 32'(tx), 32'(1));
    chk("midrst_baud_en", 32'(baud_en), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      #2;
      chk("no_resend_tx", 32'(tx), 32'(1));
      chk("no_resend_baud_en", 32'(baud_en), 32'(0));
    end
    @(negedge clk);
    a     = acc_cnt;
    cap_n = 0;
    send_byte(8'h3C);
    wait_idle();
    chk("3c_accepts", 32'(acc_cnt - a), 32'(1));
    chk("3c_len", 32'(cap_n), 32'(FRAME_LEN));
`ifdef UART_TX_PARITY_EN
    chk("3c_bits", 32'(cap[10:0]), 32'(11'b00011110001));

    // Parity bit values.
    cap_n = 0;
    send_byte(8'h07);
    wait_idle();
    chk("par_07", 32'(cap[1]), 32'(1'b1 ^ (PARITY_ODD != 0)));
    send_byte(8'h03);
    wait_idle();
    chk("par_03", 32'(cap[1]), 32'(1'b0 ^ (PARITY_ODD != 0)));
`else
    chk("3c_bits", 32'(cap[9:0]), 32'(10'b0001111001));
`endif

    // Randomized traffic: random words, gaps and back-to-back runs.
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(DATA_BITS'($urandom));
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
